// File: rtl/data_memory_ctrl.sv
// Single-port data memory behind a valid/ready request port.
// After reset the array is zero-filled one word per cycle, then requests are
// served one per cycle. Reads come back through a READ_LATENCY-deep pipeline.
module data_memory_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int MEMORY_SIZE  = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  localparam logic STATE_CLEAR = 1'b0;
  localparam logic STATE_READY = 1'b1;

  // One extra bit so the bound compare works when MEMORY_SIZE == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_SIZE - 1);

  // Reject illegal configurations while elaborating.
  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("data_memory_ctrl: READ_LATENCY must be in 1..4");
    end
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("data_memory_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (MEMORY_SIZE < 1 || MEMORY_SIZE > (2 ** ADDR_WIDTH)) begin : g_bad_size
      $error("data_memory_ctrl: MEMORY_SIZE must be in 1..2**ADDR_WIDTH");
    end
  endgenerate

  logic                  state_reg;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg;

  logic [DATA_WIDTH-1:0] mem [MEMORY_SIZE];

  logic                  pipe_valid_reg [READ_LATENCY];
  logic                  pipe_error_reg [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_reg  [READ_LATENCY];

  logic                  clearing;
  logic                  accept;
  logic                  addr_in_range;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [NUM_BYTES-1:0]  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign clearing      = (state_reg == STATE_CLEAR);
  assign req_ready     = (state_reg == STATE_READY);
  assign busy          = clearing;
  assign accept        = req_valid && req_ready && !rst;
  assign addr_in_range = ({1'b0, req_addr} < MEM_LIMIT);
  assign wr_accept     = accept && req_write && addr_in_range;
  assign rd_accept     = accept && !req_write;

  // The single write port is shared: zero-fill owns it during CLEAR.
  assign mem_waddr = clearing ? clr_cnt_reg : req_addr;
  assign mem_wdata = clearing ? '0 : req_wdata;

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      assign mem_we[gi] = clearing || (wr_accept && req_be[gi]);
    end
  endgenerate

  // Zero-fill sequencer: walk every word once, then serve requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= STATE_CLEAR;
      clr_cnt_reg <= '0;
    end else if (state_reg == STATE_CLEAR) begin
      if (clr_cnt_reg == LAST_ADDR) begin
        state_reg   <= STATE_READY;
        clr_cnt_reg <= '0;
      end else begin
        clr_cnt_reg <= clr_cnt_reg + 1'b1;
      end
    end
  end

  // Byte-lane memory write; lanes without an enable keep their contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (mem_we[b]) begin
        mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // First read stage: sample the array at the acceptance edge; out-of-range
  // and idle slots carry zero data so the output is zero when not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_reg[0] <= 1'b0;
      pipe_error_reg[0] <= 1'b0;
      pipe_data_reg[0]  <= '0;
    end else begin
      pipe_valid_reg[0] <= rd_accept;
      pipe_error_reg[0] <= rd_accept && !addr_in_range;
      pipe_data_reg[0]  <= (rd_accept && addr_in_range) ? mem[req_addr] : '0;
    end
  end

  // Remaining latency stages: plain shift, flushed by reset.
  always_ff @(posedge clk) begin
    for (int s = 1; s < READ_LATENCY; s++) begin
      if (rst) begin
        pipe_valid_reg[s] <= 1'b0;
        pipe_error_reg[s] <= 1'b0;
        pipe_data_reg[s]  <= '0;
      end else begin
        pipe_valid_reg[s] <= pipe_valid_reg[s-1];
        pipe_error_reg[s] <= pipe_error_reg[s-1];
        pipe_data_reg[s]  <= pipe_data_reg[s-1];
      end
    end
  end

  assign rsp_valid = pipe_valid_reg[READ_LATENCY-1];
  assign rsp_error = pipe_error_reg[READ_LATENCY-1];
  assign rsp_rdata = pipe_data_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three configurations side by side
//   dut 0: defaults (8-bit, 256 words, latency 1)
//   dut 1: 32-bit, 200 words, latency 3
//   dut 2: 8-bit, 256 words, latency 4 (reset mid-flight)
// Reads push expected data and due cycle to a per-dut scoreboard; a monitor
// pops and compares whenever rsp_valid is seen.
module tb_data_memory_ctrl;

  localparam int LAT [3] = '{1, 3, 4};

  typedef struct {
    int          dut;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];
  exp_t sb[3][$];

  // dut 0 signals
  logic       a_rst, a_valid, a_ready, a_write, a_rsp_valid, a_err, a_busy;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic [0:0] a_be;
  // dut 1 signals
  logic        b_rst, b_valid, b_ready, b_write, b_rsp_valid, b_err, b_busy;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_be;
  // dut 2 signals
  logic       c_rst, c_valid, c_ready, c_write, c_rsp_valid, c_err, c_busy;
  logic [7:0] c_addr, c_wdata, c_rdata;
  logic [0:0] c_be;

  data_memory_ctrl u_dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_error(a_err), .busy(a_busy)
  );

  data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEMORY_SIZE(200), .READ_LATENCY(3)) u_dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_error(b_err), .busy(b_busy)
  );

  data_memory_ctrl #(.READ_LATENCY(4)) u_dut_c (
    .clk(clk), .rst(c_rst), .req_valid(c_valid), .req_ready(c_ready),
    .req_write(c_write), .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata), .rsp_error(c_err), .busy(c_busy)
  );

  logic        rv  [3];
  logic        rer [3];
  logic        rdy [3];
  logic [31:0] rdd [3];
  assign rv[0]  = a_rsp_valid;  assign rv[1]  = b_rsp_valid;  assign rv[2]  = c_rsp_valid;
  assign rer[0] = a_err;        assign rer[1] = b_err;        assign rer[2] = c_err;
  assign rdy[0] = a_ready;      assign rdy[1] = b_ready;      assign rdy[2] = c_ready;
  assign rdd[0] = {24'h0, a_rdata};
  assign rdd[1] = b_rdata;
  assign rdd[2] = {24'h0, c_rdata};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void add(input int d, input logic wr, input logic [7:0] addr,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic [31:0] ex, input logic er);
    vec_t v;
    v.dut = d; v.wr = wr; v.addr = addr; v.wdata = wd; v.be = be;
    v.exp_data = ex; v.exp_err = er;
    vecs.push_back(v);
  endfunction

  task automatic idle_all();
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
  endtask

  task automatic drive(input int d, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    case (d)
      0: begin a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd[7:0]; a_be = be[0:0]; end
      1: begin b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wd;      b_be = be;      end
      default: begin c_valid = 1'b1; c_write = wr; c_addr = addr; c_wdata = wd[7:0]; c_be = be[0:0]; end
    endcase
  endtask

  // One request per call, driven at the falling edge and accepted at the next rise.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    idle_all();
    check($sformatf("req_ready dut%0d", v.dut), {31'h0, rdy[v.dut]}, 32'h1);
    drive(v.dut, v.wr, v.addr, v.wdata, v.be);
    if (v.wr) begin
      $display("dut%0d WRITE addr=0x%02h data=0x%08h be=0x%0h", v.dut, v.addr, v.wdata, v.be);
    end else begin
      e.data = v.exp_data;
      e.err  = v.exp_err;
      e.due  = cyc + LAT[v.dut];
      sb[v.dut].push_back(e);
      $display("dut%0d READ  addr=0x%02h expect data=0x%08h err=%0b", v.dut, v.addr, v.exp_data, v.exp_err);
    end
  endtask

  // Response monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rv[d] === 1'b1) begin
        if (sb[d].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 data=0x%0h, required no response", d, rdd[d]);
        end else begin
          e = sb[d].pop_front();
          $display("dut%0d RSP   data=0x%08h err=%0b cycle=%0d", d, rdd[d], rer[d], cyc);
          check($sformatf("rsp_cycle dut%0d", d), cyc, e.due);
          check($sformatf("rsp_rdata dut%0d", d), rdd[d], e.data);
          check($sformatf("rsp_error dut%0d", d), {31'h0, rer[d]}, {31'h0, e.err});
        end
      end else if (cyc > 0) begin
        check($sformatf("idle_rdata dut%0d", d), rdd[d], 32'h0);
        check($sformatf("idle_error dut%0d", d), {31'h0, rer[d]}, 32'h0);
      end
    end
  end

  initial begin
    int cnt;
    vec_t v;

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    c_write = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
    idle_all();

    // Reset held for two edges.
    @(negedge clk);
    check("rst_busy", {31'h0, a_busy}, 32'h1);
    check("rst_ready", {31'h0, a_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    check("post_rst_busy", {31'h0, a_busy}, 32'h1);
    check("post_rst_ready", {31'h0, a_ready}, 32'h0);

    // Zero-fill must take exactly MEMORY_SIZE cycles.
    cnt = 0;
    while (a_busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("clear_cycles dut0", cnt, 256);
    check("ready_after_clear dut0", {31'h0, a_ready}, 32'h1);
    check("busy_after_clear dut1", {31'h0, b_busy}, 32'h0);
    check("busy_after_clear dut2", {31'h0, c_busy}, 32'h0);

    // dut 0: zero-fill readback, read-after-write, be=0 no-op
    add(0, 0, 8'h00, 0, 0, 32'h00, 0);
    add(0, 0, 8'h7F, 0, 0, 32'h00, 0);
    add(0, 0, 8'hFF, 0, 0, 32'h00, 0);
    add(0, 1, 8'h10, 32'h5A, 4'h1, 0, 0);
    add(0, 0, 8'h10, 0, 0, 32'h5A, 0);
    add(0, 1, 8'h20, 32'h33, 4'h0, 0, 0);
    add(0, 0, 8'h20, 0, 0, 32'h00, 0);
    add(0, 1, 8'h7F, 32'hC3, 4'h1, 0, 0);
    add(0, 0, 8'h7F, 0, 0, 32'hC3, 0);
    add(0, 0, 8'h10, 0, 0, 32'h5A, 0);
    // dut 1: byte enables, streaming reads, out of range
    add(1, 1, 8'd5, 32'hDEADBEEF, 4'hF, 0, 0);
    add(1, 1, 8'd5, 32'h11223344, 4'b0101, 0, 0);
    add(1, 0, 8'd5, 0, 0, 32'hDE22BE44, 0);
    add(1, 1, 8'd1, 32'hA1, 4'hF, 0, 0);
    add(1, 1, 8'd2, 32'hA2, 4'hF, 0, 0);
    add(1, 1, 8'd3, 32'hA3, 4'hF, 0, 0);
    add(1, 0, 8'd1, 0, 0, 32'hA1, 0);
    add(1, 0, 8'd2, 0, 0, 32'hA2, 0);
    add(1, 0, 8'd3, 0, 0, 32'hA3, 0);
    add(1, 1, 8'd210, 32'hFF, 4'hF, 0, 0);
    add(1, 0, 8'd210, 0, 0, 32'h00, 1);
    add(1, 0, 8'd199, 0, 0, 32'h00, 0);
    add(1, 0, 8'd10, 0, 0, 32'h00, 0);
    add(1, 0, 8'hFF, 0, 0, 32'h00, 1);
    // dut 2: basic write/read at latency 4
    add(2, 1, 8'h10, 32'h77, 4'h1, 0, 0);
    add(2, 0, 8'h10, 0, 0, 32'h77, 0);
    add(2, 0, 8'h11, 0, 0, 32'h00, 0);

    foreach (vecs[i]) apply(vecs[i]);
    @(negedge clk);
    idle_all();
    repeat (10) @(negedge clk);

    // dut 2: reset one cycle after a read is accepted; that read must vanish.
    drive(2, 1'b0, 8'h10, 32'h0, 4'h0);
    @(negedge clk);
    idle_all();
    c_rst = 1'b1;
    @(negedge clk);
    c_rst = 1'b0;
    check("midflight_busy dut2", {31'h0, c_busy}, 32'h1);
    check("midflight_ready dut2", {31'h0, c_ready}, 32'h0);
    cnt = 0;
    while (c_busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("clear_cycles dut2", cnt, 256);
    v.dut = 2; v.wr = 1'b0; v.addr = 8'h10; v.wdata = '0; v.be = '0;
    v.exp_data = 32'h0; v.exp_err = 1'b0;
    apply(v);
    @(negedge clk);
    idle_all();

    repeat (8) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("pending_rsp dut%0d", d), sb[d].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised single-port data memory behind a valid/ready request port with a pipelined read-response channel.
- Adds features the first-generation data memory lacks: configurable data and address width, per-byte write enables, configurable read latency, out-of-range detection, and hardware zero-fill after reset.
- Serves as the processor-side data store; the load/store unit drives requests and consumes responses.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word-address width.
- MEMORY_SIZE, 256, number of words; must be at most 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read acceptance to response; legal range 1..4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high together with req_valid.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- req_be  input  DATA_WIDTH/8  byte enables for writes; bit i selects bits [8i+7:8i].
- rsp_valid  output  1  read data valid; one-cycle pulse per accepted read; no backpressure.
- rsp_rdata  output  DATA_WIDTH  read data; 0 whenever rsp_valid is 0.
- rsp_error  output  1  qualifies rsp_valid; read address was out of range.
- busy  output  1  zero-fill in progress.

Behaviour:
- Reset (rst high at a rising edge):
  - Next cycle: FSM enters CLEAR and the clear counter is 0.
  - busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - All read-pipeline stages are flushed.
- FSM has two states, CLEAR and READY.
- CLEAR:
  - Each cycle writes all-zero to word[counter], then increments the counter.
  - After writing word MEMORY_SIZE-1, transitions to READY.
  - CLEAR lasts exactly MEMORY_SIZE cycles after reset is released.
  - Requests are ignored during CLEAR because req_ready = 0.
- READY:
  - busy = 0 and req_ready = 1 every cycle (no internal stalls).
  - One request can be accepted per cycle.
- Write (accepted, req_write = 1, req_addr < MEMORY_SIZE):
  - Only bytes whose req_be bit is 1 are updated, at the acceptance edge.
  - req_be = 0 is a legal no-op.
  - Writes produce no response.
- Read (accepted, req_write = 0):
  - The word is sampled at the acceptance edge.
  - rsp_valid is high for exactly one cycle, beginning READ_LATENCY-1 cycles after the cycle following acceptance. For READ_LATENCY = 1, the response appears in the cycle right after the acceptance edge.
  - Back-to-back reads give back-to-back responses, in order.
- Read-after-write to the same address in the next cycle returns the newly written data; there is no hazard window.
- Out-of-range address (req_addr >= MEMORY_SIZE):
  - Write: memory is unchanged.
  - Read: response is still produced at normal latency, with rsp_rdata = 0 and rsp_error = 1.
- Outputs are registered; there are no combinational paths from req_* to rsp_*.
- Reset mid-operation:
  - Any in-flight responses are dropped; rsp_valid = 0 from the next cycle.
  - CLEAR restarts from address 0, including when reset is asserted during CLEAR.
- Reset held high for several cycles: the FSM stays at CLEAR with the counter at 0 until release.
- Parameter checks: illegal READ_LATENCY, DATA_WIDTH % 8 != 0, or MEMORY_SIZE > 2**ADDR_WIDTH causes an elaboration-time error.

Test Plan:
- Zero-fill timing:
  - Stimulus: defaults; rst high 2 cycles, then release.
  - Required: busy = 1 and req_ready = 0 for exactly 256 cycles, then busy = 0 and req_ready = 1.
  - Reading addresses 0x00, 0x7F and 0xFF returns 0x00 with rsp_error = 0.
- Byte-enable write:
  - Stimulus: DATA_WIDTH = 32; write 0xDEADBEEF with be = 4'hF to addr 5; then write 0x11223344 with be = 4'b0101; then read addr 5.
  - Required: rsp_rdata = 0xDE22BE44.
- Latency and streaming:
  - Stimulus: READ_LATENCY = 3; consecutive reads of addrs 1, 2, 3 holding preloaded 0xA1, 0xA2, 0xA3.
  - Required: rsp_valid high for 3 consecutive cycles, with the first response 3 cycles after the first acceptance edge; data in order 0xA1, 0xA2, 0xA3.
- Read-after-write:
  - Stimulus: write 0x5A to addr 0x10; read addr 0x10 on the next cycle.
  - Required: response returns 0x5A.
- Out of range:
  - Stimulus: MEMORY_SIZE = 200; write 0xFF to addr 210; then read addr 210; then read addr 199.
  - Required: first read gives rsp_error = 1 and rsp_rdata = 0x00; read of addr 199 returns 0x00 with rsp_error = 0.
- Reset mid-flight:
  - Stimulus: READ_LATENCY = 4; issue a read, then assert rst one cycle later.
  - Required: no rsp_valid pulse ever appears for that read; busy = 1 the cycle after reset; previously written addr 0x10 reads 0x00 after the new CLEAR completes.
